// File: rtl/bresp_scheduler_if.sv
// Burst-request, AHB-beat and response-FIFO signals between the AXI-to-AHB
// bridge datapath and the write-response scheduler.
interface bresp_scheduler_if;
    logic       burst_valid;
    logic [3:0] burst_len;
    logic       burst_ready;
    logic       beat_done;
    logic       beat_resp;
    logic       fifo_full;
    logic       fifo_write_en;
    logic [1:0] fifo_data;

    // Scheduler side.
    modport slave (
        input  burst_valid,
        input  burst_len,
        input  beat_done,
        input  beat_resp,
        input  fifo_full,
        output burst_ready,
        output fifo_write_en,
        output fifo_data
    );

    // Bridge datapath / FIFO side.
    modport master (
        output burst_valid,
        output burst_len,
        output beat_done,
        output beat_resp,
        output fifo_full,
        input  burst_ready,
        input  fifo_write_en,
        input  fifo_data
    );
endinterface

// File: rtl/bresp_scheduler.sv
// Tracks one AXI write burst at a time, merges its AHB beat responses into a
// single BRESP, pushes it into the response FIFO and keeps saturating stats.
module bresp_scheduler #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    bresp_scheduler_if.slave bus,
    output logic             timeout_err,
    output logic             stray_beat,
    output logic [CNT_W-1:0] resp_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam bit          WDOG_EN = (TIMEOUT != 0);
    localparam int unsigned IDLE_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = WDOG_EN ? IDLE_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_PUSH
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              err_acc_q, err_acc_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [1:0]        resp_q, resp_d;
    logic              stray_q, stray_d;
    logic              err_next;
    logic              write_en;
    logic              wdog_fire;

    // Reset gates the strobe so a PUSH state caught by reset never writes.
    assign write_en = (state_q == S_PUSH) && !bus.fifo_full && !reset;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        err_acc_d  = err_acc_q;
        idle_cnt_d = idle_cnt_q;
        resp_d     = resp_q;
        stray_d    = stray_q | (bus.beat_done && (state_q != S_ACTIVE));
        err_next   = err_acc_q | bus.beat_resp;
        wdog_fire  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.burst_valid) begin
                    beat_cnt_d = bus.burst_len;
                    err_acc_d  = 1'b0;
                    idle_cnt_d = '0;
                    state_d    = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (bus.beat_done) begin
                    err_acc_d  = err_next;
                    idle_cnt_d = '0;
                    if (beat_cnt_q == 4'd0) begin
                        resp_d  = err_next ? RESP_SLVERR : RESP_OKAY;
                        state_d = S_PUSH;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 4'd1;
                    end
                end else if (WDOG_EN && (idle_cnt_q == IDLE_LAST)) begin
                    // A stalled burst is reported as DECERR regardless of
                    // any SLVERR already collected.
                    wdog_fire = 1'b1;
                    resp_d    = RESP_DECERR;
                    state_d   = S_PUSH;
                end else if (WDOG_EN) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end

            S_PUSH: begin
                if (write_en) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            err_acc_q  <= 1'b0;
            idle_cnt_q <= '0;
            resp_q     <= RESP_OKAY;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            err_acc_q  <= err_acc_d;
            idle_cnt_q <= idle_cnt_d;
            resp_q     <= resp_d;
            stray_q    <= stray_d;
        end
    end

    // Statistics: index 0 counts every write, index 1 only non-OKAY writes.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = write_en;
    assign cnt_inc[1] = write_en && (resp_q != RESP_OKAY);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && !(&cnt_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    assign bus.burst_ready   = (state_q == S_IDLE);
    assign bus.fifo_write_en = write_en;
    assign bus.fifo_data     = resp_q;
    assign timeout_err       = wdog_fire;
    assign stray_beat        = stray_q;
    assign resp_cnt          = cnt_val[0];
    assign err_cnt           = cnt_val[1];

endmodule

// File: tb/tb_bresp_scheduler.sv
// Randomized and directed bursts against a transaction-level model of the
// write-response scheduler; a second 2-bit-counter copy checks saturation.
module tb_bresp_scheduler;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bresp_scheduler_if bus ();
    bresp_scheduler_if bus_s ();

    logic        timeout_err, stray_beat;
    logic [15:0] resp_cnt, err_cnt;
    logic        timeout_err_s, stray_beat_s;
    logic [1:0]  resp_cnt_s, err_cnt_s;

    assign bus_s.burst_valid = bus.burst_valid;
    assign bus_s.burst_len   = bus.burst_len;
    assign bus_s.beat_done   = bus.beat_done;
    assign bus_s.beat_resp   = bus.beat_resp;
    assign bus_s.fifo_full   = bus.fifo_full;

    bresp_scheduler #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .timeout_err (timeout_err),
        .stray_beat  (stray_beat),
        .resp_cnt    (resp_cnt),
        .err_cnt     (err_cnt)
    );

    bresp_scheduler #(.TIMEOUT(TO), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_s),
        .timeout_err (timeout_err_s),
        .stray_beat  (stray_beat_s),
        .resp_cnt    (resp_cnt_s),
        .err_cnt     (err_cnt_s)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int m_resp = 0;
    int m_err = 0;
    bit m_stray = 1'b0;
    int n_burst = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic check_common(input bit exp_ready, input bit exp_we, input bit exp_to);
        check("burst_ready", 32'(bus.burst_ready), 32'(exp_ready));
        check("fifo_write_en", 32'(bus.fifo_write_en), 32'(exp_we));
        check("timeout_err", 32'(timeout_err), 32'(exp_to));
        check("stray_beat", 32'(stray_beat), 32'(m_stray));
        check("resp_cnt", 32'(resp_cnt), 32'(sat(m_resp, 16)));
        check("err_cnt", 32'(err_cnt), 32'(sat(m_err, 16)));
        check("sat_write_en", 32'(bus_s.fifo_write_en), 32'(exp_we));
        check("sat_resp_cnt", 32'(resp_cnt_s), 32'(sat(m_resp, 2)));
        check("sat_err_cnt", 32'(err_cnt_s), 32'(sat(m_err, 2)));
    endtask

    // mode: 0 no beats, 1 random stray beats, 2 a stray beat every cycle
    task automatic idle_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            bus.burst_valid = 1'b0;
            bus.burst_len   = 4'($urandom);
            bus.beat_done   = (mode == 2) || ((mode == 1) && ($urandom_range(0, 4) == 0));
            bus.beat_resp   = 1'($urandom);
            bus.fifo_full   = 1'($urandom);
            @(negedge clk);
            check_common(1'b1, 1'b0, 1'b0);
            @(posedge clk);
            if (bus.beat_done) m_stray = 1'b1;
            #1;
        end
        bus.beat_done = 1'b0;
    endtask

    task automatic do_burst(input int len, input logic [15:0] err_mask, input int gap_max,
                            input int silent_after, input int full_cycles, input bit stray_accept);
        int         beats;
        int         run;
        int         g;
        bit         any_err;
        bit         timed_out;
        logic [1:0] exp_resp;
        beats = 0; run = 0; any_err = 1'b0; timed_out = 1'b0;

        bus.burst_valid = 1'b1;
        bus.burst_len   = 4'(len);
        bus.beat_done   = stray_accept;
        bus.beat_resp   = 1'($urandom);
        bus.fifo_full   = 1'($urandom);
        @(negedge clk);
        check_common(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        if (stray_accept) m_stray = 1'b1;
        #1;
        bus.burst_valid = 1'b0;

        while ((beats < len + 1) && !timed_out) begin
            g = ((silent_after >= 0) && (beats >= silent_after)) ? 1000 : $urandom_range(0, gap_max);
            for (int k = 0; k < g && !timed_out; k++) begin
                bus.beat_done = 1'b0;
                bus.beat_resp = 1'($urandom);
                bus.burst_len = 4'($urandom);
                bus.fifo_full = 1'($urandom);
                run++;
                @(negedge clk);
                check_common(1'b0, 1'b0, run == TO);
                if (run == TO) timed_out = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!timed_out) begin
                bus.beat_done = 1'b1;
                bus.beat_resp = err_mask[beats];
                bus.fifo_full = 1'($urandom);
                any_err       = any_err | err_mask[beats];
                run           = 0;
                @(negedge clk);
                check_common(1'b0, 1'b0, 1'b0);
                @(posedge clk);
                #1;
                beats++;
                bus.beat_done = 1'b0;
            end
        end

        exp_resp = timed_out ? 2'b11 : (any_err ? 2'b10 : 2'b00);

        for (int k = 0; k < full_cycles; k++) begin
            bus.fifo_full = 1'b1;
            bus.beat_done = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            check_common(1'b0, 1'b0, 1'b0);
            check("fifo_data_held", 32'(bus.fifo_data), 32'(exp_resp));
            @(posedge clk);
            if (bus.beat_done) m_stray = 1'b1;
            #1;
        end

        bus.fifo_full = 1'b0;
        bus.beat_done = ($urandom_range(0, 5) == 0);
        @(negedge clk);
        check_common(1'b0, 1'b1, 1'b0);
        check("fifo_data", 32'(bus.fifo_data), 32'(exp_resp));
        @(posedge clk);
        if (bus.beat_done) m_stray = 1'b1;
        m_resp++;
        if (exp_resp != 2'b00) m_err++;
        #1;
        bus.beat_done = 1'b0;
        n_burst++;
        $display("burst %0d: len=%0d beats=%0d full=%0d resp=%b timeout=%0d", n_burst, len,
                 beats, full_cycles, exp_resp, timed_out);
    endtask

    initial begin
        reset           = 1'b1;
        bus.burst_valid = 1'b0;
        bus.burst_len   = 4'd0;
        bus.beat_done   = 1'b0;
        bus.beat_resp   = 1'b0;
        bus.fifo_full   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check_common(1'b1, 1'b0, 1'b0);
        check("reset_fifo_data", 32'(bus.fifo_data), 32'd0);
        @(posedge clk);
        #1;

        // Four back-to-back OKAY beats.
        do_burst(3, 16'h0000, 0, -1, 0, 1'b0);
        // Eight beats, ERROR on beat 3 only.
        do_burst(7, 16'h0008, 0, -1, 0, 1'b0);
        idle_cycles(2, 0);
        // Last beat lands while the FIFO stays full for 10 cycles.
        do_burst(2, 16'h0004, 0, -1, 10, 1'b0);
        // One beat then silence: watchdog DECERR, then a stray beat in IDLE.
        do_burst(2, 16'h0000, 0, 1, 0, 1'b0);
        idle_cycles(1, 2);
        idle_cycles(2, 0);
        // Error bursts drive the 2-bit counters into saturation.
        for (int i = 0; i < 5; i++) do_burst(0, 16'h0001, 0, -1, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            int          len;
            int          gm;
            int          silent;
            logic [15:0] mask;
            len    = $urandom_range(0, 15);
            gm     = ($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 3);
            silent = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
            mask   = 16'($urandom) & 16'($urandom) & 16'($urandom);
            do_burst(len, mask, gm, silent, $urandom_range(0, 3), 1'($urandom_range(0, 5) == 0));
            idle_cycles($urandom_range(0, 3), 1);
        end

        // Reset while PUSH is waiting on a full FIFO.
        bus.burst_valid = 1'b1;
        bus.burst_len   = 4'd0;
        bus.beat_done   = 1'b1;
        @(negedge clk);
        check_common(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        m_stray = 1'b1;
        #1;
        bus.burst_valid = 1'b0;
        bus.beat_resp   = 1'b1;
        @(negedge clk);
        check_common(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.beat_done = 1'b0;
        bus.fifo_full = 1'b1;
        @(negedge clk);
        check_common(1'b0, 1'b0, 1'b0);
        check("push_fifo_data", 32'(bus.fifo_data), 32'd2);
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        check("rst_write_en", 32'(bus.fifo_write_en), 32'd0);
        check("rst_sat_write_en", 32'(bus_s.fifo_write_en), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_resp  = 0;
        m_err   = 0;
        m_stray = 1'b0;
        @(negedge clk);
        check_common(1'b1, 1'b0, 1'b0);
        check("post_rst_fifo_data", 32'(bus.fifo_data), 32'd0);
        @(posedge clk);
        #1;
        $display("reset in PUSH: done");

        do_burst(1, 16'h0002, 1, -1, 1, 1'b0);
        idle_cycles(2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bresp_scheduler.md
# bresp_scheduler

Write-response scheduler for the AXI-to-AHB bridge. It tracks each accepted AXI write burst while its beats complete on AHB, and merges the per-beat AHB responses into one AXI BRESP. It pushes that BRESP into the response FIFO write port, holding it under FIFO backpressure. It also bounds a stalled burst with a watchdog and keeps saturating response statistics.

## Interface
- TIMEOUT, 256: consecutive beat-less cycles in ACTIVE before forced termination; 0 disables the watchdog.
- CNT_W, 16: width of the statistics counters.
- clk  input  1  single clock; the response FIFO write clock.
- reset  input  1  synchronous, active-high.
- burst_valid  input  1  new AXI write burst offered.
- burst_len  input  4  beats minus one (AWLEN[3:0]).
- burst_ready  output  1  burst accepted when valid && ready.
- beat_done  input  1  one AHB data beat completed this cycle.
- beat_resp  input  1  HRESP of that beat: 0 OKAY, 1 ERROR.
- fifo_full  input  1  response FIFO full flag.
- fifo_write_en  output  1  FIFO write strobe.
- fifo_data  output  2  BRESP: 00 OKAY, 10 SLVERR, 11 DECERR.
- timeout_err  output  1  one-cycle pulse when the watchdog fires.
- stray_beat  output  1  sticky; a beat_done arrived outside ACTIVE.
- resp_cnt  output  CNT_W  responses written, saturating.
- err_cnt  output  CNT_W  non-OKAY responses written, saturating.

## Operation
- States are IDLE, ACTIVE and PUSH.
- IDLE:
  - burst_ready = 1.
  - On burst_valid, load beat_cnt <= burst_len, clear err_acc, clear idle_cnt, go to ACTIVE.
- ACTIVE:
  - burst_ready = 0.
  - On beat_done: err_acc |= beat_resp, idle_cnt <= 0.
  - If beat_done && beat_cnt == 0: latch resp = err_acc_next ? 10 : 00, go to PUSH.
  - Otherwise on beat_done: beat_cnt <= beat_cnt - 1.
  - If no beat_done: idle_cnt++.
  - Watchdog: if TIMEOUT != 0 and idle_cnt == TIMEOUT-1 with no beat_done, latch resp = 11, pulse timeout_err, go to PUSH. DECERR overrides any accumulated SLVERR.
- PUSH:
  - fifo_write_en = !fifo_full (combinational), fifo_data = latched resp.
  - When fifo_write_en is high, go to IDLE next cycle.
  - While fifo_full is high, hold PUSH indefinitely with resp stable. The watchdog does not run in PUSH.
- beat_done in IDLE or PUSH:
  - The beat is ignored and does not affect any response.
  - stray_beat is set and stays set until reset.
- Counters:
  - On each FIFO write, resp_cnt++ and, if resp != 00, err_cnt++.
  - Both saturate at all-ones and never wrap.
- Widths:
  - beat_cnt is 4 bits, so 1 to 16 beats per burst.
  - idle_cnt is wide enough to hold TIMEOUT-1.
- Reset:
  - Returns to IDLE and discards any latched response.
  - fifo_write_en is forced 0 during every cycle reset is high, even if the state register holds PUSH.
- Reset values: burst_ready 1 (first cycle after reset), fifo_write_en 0, fifo_data 00, timeout_err 0, stray_beat 0, resp_cnt 0, err_cnt 0.

## Timing
- Burst handshake at edge N puts the block in ACTIVE from cycle N+1; burst_ready is low in N+1.
- A beat_done coincident with the acceptance cycle (IDLE) is a stray beat, not the first beat.
- Last beat_done in cycle M: PUSH in M+1, and fifo_write_en in M+1 if fifo_full is low.
- Minimum burst-to-burst turnaround:
  - Accept in cycle A, last beat in A+1, write in A+2, IDLE in A+3.
  - burst_ready reasserts in A+3.
- fifo_write_en is at most one cycle per response; there are never duplicate writes.
- Watchdog: with no beats after entering ACTIVE, timeout_err and the PUSH transition occur at the TIMEOUT-th ACTIVE cycle. The write is in the next cycle.
- fifo_data is stable from PUSH entry until the write cycle inclusive.

## Test plan
- Single burst, burst_len=3, four OKAY beats back-to-back, fifo_full=0 -> exactly one fifo_write_en with fifo_data=00 one cycle after the 4th beat; resp_cnt=1, err_cnt=0.
- Burst_len=7 with ERROR on beat 3 only -> single write with fifo_data=10; err_cnt=1; burst_ready low for the whole burst.
- Last beat completes while fifo_full=1 held 10 cycles -> PUSH held, no write, and fifo_data=10 stable for all 10 cycles. The write occurs in the first cycle fifo_full=0; burst_ready returns the cycle after.
- TIMEOUT=8, burst_len=2, one beat then silence -> timeout_err pulses after 8 beat-less cycles, write fifo_data=11. A later beat_done sets stray_beat=1 with no extra write.
- Reset asserted for one cycle while in PUSH with fifo_full=0 -> no write in that cycle; next cycle IDLE with counters 0, burst_ready=1, stray_beat=0.
- Preload counters near saturation (CNT_W=2) and run 5 ERROR bursts -> resp_cnt and err_cnt saturate at 3 and do not wrap.
